// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared encodings and constants for the unified-memory port arbiter.
//   owner_e      : which requester owns the current access (fetch / data)
//   arb_state_e  : arbiter FSM states
//   LAT_CNT_W    : width of the latency counter
//   MEM_LAT_MAX  : largest latency the counter can time
//   lat_load()   : counter load value for a given latency
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   localparam int LAT_CNT_W   = 4;
   localparam int MEM_LAT_MAX = (1 << LAT_CNT_W) - 1;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_D  = 1'b1
   } owner_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // The issue cycle itself counts as the first latency cycle, so the
   // counter starts one below the latency and completion is seen at zero.
   function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
      return LAT_CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_mem_lat_timer.sv
// ---------------------------------------------------------------------------
// mem_lat_timer
// Loadable down-counter that times the fixed memory latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (access issued)
//   load_val   : start value (latency - 1)
//   done       : counter is at zero
// The counter saturates at zero when not reloaded.
// ---------------------------------------------------------------------------
module mem_lat_timer
   import mem_port_arbiter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [LAT_CNT_W-1:0] load_val,
   output logic                 done
);

   logic [LAT_CNT_W-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its inputs from before the edge, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares a single-ported unified memory between instruction fetch and the
// load/store path. One access in flight at a time; completion is timed by
// a fixed memory latency.
//   if_req/if_addr            : fetch request (held until if_valid)
//   if_gnt/if_valid/if_rdata  : fetch issued / fetch complete + data
//   d_req/d_we/d_addr/d_wdata : load/store request (held until d_valid)
//   d_gnt/d_valid/d_rdata     : data issued / data complete + load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory-side port
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..15).
// Build option: define MEM_ARB_RR_EN for round-robin selection between
// simultaneous requests; otherwise data has fixed priority over fetch.
// ---------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT=%0d outside 1..%0d", MEM_LAT, MEM_LAT_MAX);
   end

   arb_state_e state;
   owner_e     owner;
   owner_e     last_owner;
   owner_e     sel;
   logic       owner_we;
   logic       issue;
   logic       complete;
   logic       lat_done;

   // The issue decision is combinational so gnt and the memory strobe land
   // in the request cycle; gating with rst_n keeps the port quiet while
   // reset is held even if requesters keep their req high.
   assign issue    = rst_n && (state == ARB_IDLE) && (if_req || d_req);
   assign complete = (state == ARB_BUSY) && lat_done;

`ifdef MEM_ARB_RR_EN
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      sel = OWNER_IF;
      if (if_req && d_req) begin
         if (last_owner == OWNER_D) sel = OWNER_IF;
         else                       sel = OWNER_D;
      end else if (d_req) begin
         sel = OWNER_D;
      end
   end
`else
   // Data wins ties: it belongs to the older instruction in the pipeline.
   always_comb begin
      sel = OWNER_IF;
      if (d_req) sel = OWNER_D;
   end

   logic unused_last_owner;
   assign unused_last_owner = logic'(last_owner);
`endif

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (issue) begin
         mem_en = 1'b1;
         if (sel == OWNER_D) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
         end else begin
            mem_addr  = if_addr;
         end
      end
   end

   assign if_gnt   = issue && (sel == OWNER_IF);
   assign d_gnt    = issue && (sel == OWNER_D);
   assign if_valid = complete && (owner == OWNER_IF);
   assign d_valid  = complete && (owner == OWNER_D);
   // Stores complete with zero read data; the memory's read bus is not
   // meaningful for a write.
   assign if_rdata = if_valid ? mem_rdata : '0;
   assign d_rdata  = (d_valid && !owner_we) ? mem_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         owner      <= OWNER_D;
         owner_we   <= 1'b0;
         last_owner <= OWNER_D;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (issue) begin
                  state      <= ARB_BUSY;
                  owner      <= sel;
                  owner_we   <= (sel == OWNER_D) && d_we;
                  last_owner <= sel;
               end
            end
            ARB_BUSY: begin
               if (lat_done) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   mem_lat_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (issue),
      .load_val (lat_load(MEM_LAT)),
      .done     (lat_done)
   );

endmodule
